transition_window_counter: RTL and testbench

- Sits directly downstream of the 1-bit digital differentiator stage.
- Consumes its per-sample transition flag (diff_in, qualified by diff_valid).
- Counts transitions over a programmable window of qualified samples and presents each window's total through a registered valid/ready output.
- Used for toggle-rate and activity measurement on slow serial or status lines.

---
 rtl/transition_window_counter_if.sv | 33 +++
 rtl/transition_window_counter.sv | 145 ++++++++++++++
 tb/tb_transition_window_counter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/transition_window_counter_if.sv
//------------------------------------------------------------------------------
// transition_window_counter_if : control, sample and result-handshake bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface transition_window_counter_if #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
);
  logic             enable;
  logic [WIN_W-1:0] win_len;
  logic             diff_in;
  logic             diff_valid;
  logic [CNT_W-1:0] count_out;
  logic             overflow;
  logic             count_valid;
  logic             count_ready;
  logic             missed;
  logic             busy;

  modport master (
    output enable, win_len, diff_in, diff_valid, count_ready,
    input  count_out, overflow, count_valid, missed, busy
  );

  modport slave (
    input  enable, win_len, diff_in, diff_valid, count_ready,
    output count_out, overflow, count_valid, missed, busy
  );
endinterface

`default_nettype wire

// File: rtl/transition_window_counter.sv
//------------------------------------------------------------------------------
// transition_window_counter : counts differentiator transitions per window of
// qualified samples and presents each total through a valid/ready register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module transition_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  transition_window_counter_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           state_q,       state_d;
  logic [WIN_W-1:0] win_len_q,     win_len_d;
  logic [WIN_W-1:0] samp_cnt_q,    samp_cnt_d;
  logic [CNT_W-1:0] evt_cnt_q,     evt_cnt_d;
  logic             sat_q,         sat_d;
  logic [CNT_W-1:0] count_out_q,   count_out_d;
  logic             overflow_q,    overflow_d;
  logic             count_valid_q, count_valid_d;
  logic             missed_q,      missed_d;

  logic [WIN_W-1:0] w_samp_next;
  logic [CNT_W-1:0] w_evt_next;
  logic             w_sat_next;
  logic [WIN_W-1:0] w_win_len_eff;
  logic             w_can_load;

  always_comb begin
    state_d       = state_q;
    win_len_d     = win_len_q;
    samp_cnt_d    = samp_cnt_q;
    evt_cnt_d     = evt_cnt_q;
    sat_d         = sat_q;
    count_out_d   = count_out_q;
    overflow_d    = overflow_q;
    count_valid_d = count_valid_q;
    missed_d      = 1'b0;

    w_samp_next   = samp_cnt_q + WIN_W'(1);
    w_evt_next    = evt_cnt_q;
    w_sat_next    = sat_q;
    if (bus.diff_in) begin
      if (evt_cnt_q == CNT_MAX) begin
        w_sat_next = 1'b1;
      end else begin
        w_evt_next = evt_cnt_q + CNT_W'(1);
      end
    end

    // A zero-length window would never complete, so it runs as one sample.
    w_win_len_eff = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
    w_can_load    = !count_valid_q || bus.count_ready;

    if (count_valid_q && bus.count_ready) begin
      count_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          win_len_d  = w_win_len_eff;
          samp_cnt_d = '0;
          evt_cnt_d  = '0;
          sat_d      = 1'b0;
          state_d    = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!bus.enable) begin
          samp_cnt_d = '0;
          evt_cnt_d  = '0;
          sat_d      = 1'b0;
          state_d    = S_IDLE;
        end else if (bus.diff_valid) begin
          if (w_samp_next == win_len_q) begin
            if (w_can_load) begin
              count_out_d   = w_evt_next;
              overflow_d    = w_sat_next;
              count_valid_d = 1'b1;
            end else begin
              missed_d = 1'b1;
            end
            // Relatch in the completion cycle so windows run back to back.
            win_len_d  = w_win_len_eff;
            samp_cnt_d = '0;
            evt_cnt_d  = '0;
            sat_d      = 1'b0;
          end else begin
            samp_cnt_d = w_samp_next;
            evt_cnt_d  = w_evt_next;
            sat_d      = w_sat_next;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      win_len_q     <= '0;
      samp_cnt_q    <= '0;
      evt_cnt_q     <= '0;
      sat_q         <= 1'b0;
      count_out_q   <= '0;
      overflow_q    <= 1'b0;
      count_valid_q <= 1'b0;
      missed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_len_q     <= win_len_d;
      samp_cnt_q    <= samp_cnt_d;
      evt_cnt_q     <= evt_cnt_d;
      sat_q         <= sat_d;
      count_out_q   <= count_out_d;
      overflow_q    <= overflow_d;
      count_valid_q <= count_valid_d;
      missed_q      <= missed_d;
    end
  end

  assign bus.count_out   = count_out_q;
  assign bus.overflow    = overflow_q;
  assign bus.count_valid = count_valid_q;
  assign bus.missed      = missed_q;
  assign bus.busy        = (state_q == S_COUNT);

endmodule

`default_nettype wire

// File: tb/tb_transition_window_counter.sv
//------------------------------------------------------------------------------
// tb_transition_window_counter : scoreboard bench for transition_window_counter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_transition_window_counter;

  localparam int CNT_W = 2;
  localparam int WIN_W = 16;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Expected accepted results: {count_out, overflow}
  logic [CNT_W:0] sb_q[$];

  transition_window_counter_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) tif ();

  transition_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic v, input logic d);
    tif.diff_valid = v;
    tif.diff_in    = d;
    step();
  endtask

  task automatic push(input int cnt, input logic ovf);
    sb_q.push_back({cnt[CNT_W-1:0], ovf});
  endtask

  // Every transfer (valid & ready ahead of an edge) retires one expected result.
  always @(negedge clk) begin
    logic [CNT_W:0] e;
    if (rst_n && tif.count_valid && tif.count_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_count", 32'(tif.count_out), 32'(e[CNT_W:1]));
        check("sb_ovf", 32'(tif.overflow), 32'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    tif.enable      = 1'b0;
    tif.win_len     = '0;
    tif.diff_in     = 1'b0;
    tif.diff_valid  = 1'b0;
    tif.count_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(tif.count_valid), 0);
    check("rst_count", 32'(tif.count_out), 0);
    check("rst_busy", 32'(tif.busy), 0);
    rst_n = 1'b1;
    step();

    // Basic window of 4: 1,0,1,1 -> 3
    tif.count_ready = 1'b1;
    tif.enable      = 1'b1;
    tif.win_len     = 16'd4;
    step();
    check("basic_busy", 32'(tif.busy), 1);
    push(3, 1'b0);
    smp(1, 1); smp(1, 0); smp(1, 1);
    check("basic_not_yet", 32'(tif.count_valid), 0);
    smp(1, 1);
    check("basic_valid", 32'(tif.count_valid), 1);
    check("basic_count", 32'(tif.count_out), 3);
    tif.enable = 1'b0;
    smp(0, 0);
    check("basic_cleared", 32'(tif.count_valid), 0);
    check("basic_idle", 32'(tif.busy), 0);

    // Gaps: invalid cycles carrying diff_in=1 are ignored
    tif.enable  = 1'b1;
    tif.win_len = 16'd3;
    step();
    push(2, 1'b0);
    smp(1, 1); smp(0, 1); smp(1, 1); smp(0, 1); smp(0, 1);
    check("gap_not_yet", 32'(tif.count_valid), 0);
    smp(1, 0);
    check("gap_valid", 32'(tif.count_valid), 1);
    check("gap_count", 32'(tif.count_out), 2);
    tif.enable = 1'b0;
    smp(0, 1);

    // Saturation then a clean all-zero window
    tif.enable  = 1'b1;
    tif.win_len = 16'd5;
    step();
    push(3, 1'b1);
    for (int i = 0; i < 5; i++) smp(1, 1);
    check("sat_count", 32'(tif.count_out), 3);
    check("sat_ovf", 32'(tif.overflow), 1);
    push(0, 1'b0);
    for (int i = 0; i < 5; i++) smp(1, 0);
    check("zero_count", 32'(tif.count_out), 0);
    check("zero_ovf", 32'(tif.overflow), 0);
    tif.enable = 1'b0;
    smp(0, 0);

    // Backpressure: second result dropped with a one-cycle missed pulse
    tif.count_ready = 1'b0;
    tif.enable      = 1'b1;
    tif.win_len     = 16'd2;
    step();
    smp(1, 1); smp(1, 1);
    check("bp_valid", 32'(tif.count_valid), 1);
    check("bp_count", 32'(tif.count_out), 2);
    push(2, 1'b0);
    smp(1, 1);
    check("bp_no_miss", 32'(tif.missed), 0);
    smp(1, 0);
    check("bp_missed", 32'(tif.missed), 1);
    check("bp_held", 32'(tif.count_out), 2);
    tif.count_ready = 1'b1;
    smp(0, 0);
    check("bp_miss_pulse", 32'(tif.missed), 0);
    push(1, 1'b0);
    smp(1, 0); smp(1, 1);
    check("bp_third_valid", 32'(tif.count_valid), 1);
    check("bp_third_count", 32'(tif.count_out), 1);
    tif.enable = 1'b0;
    smp(0, 0);

    // win_len=0 acts as 1: a result every valid sample, no dead cycle
    tif.enable  = 1'b1;
    tif.win_len = 16'd0;
    step();
    push(1, 1'b0); push(0, 1'b0); push(1, 1'b0);
    smp(1, 1);
    check("w0_valid1", 32'(tif.count_valid), 1);
    check("w0_count1", 32'(tif.count_out), 1);
    smp(1, 0);
    check("w0_valid2", 32'(tif.count_valid), 1);
    check("w0_count2", 32'(tif.count_out), 0);
    smp(1, 1);
    check("w0_count3", 32'(tif.count_out), 1);
    check("w0_busy", 32'(tif.busy), 1);
    tif.enable = 1'b0;
    smp(0, 0);

    // Abort after 2 of 4 samples
    tif.count_ready = 1'b0;
    tif.enable      = 1'b1;
    tif.win_len     = 16'd4;
    step();
    smp(1, 1); smp(1, 1);
    tif.enable = 1'b0;
    smp(0, 0);
    check("abort_busy", 32'(tif.busy), 0);
    check("abort_noresult", 32'(tif.count_valid), 0);
    smp(1, 1); smp(1, 1);
    check("abort_stay_idle", 32'(tif.count_valid), 0);

    // Asynchronous reset while a result is held and missed is pulsing
    tif.enable  = 1'b1;
    tif.win_len = 16'd1;
    step();
    smp(1, 1);
    check("pre_rst_valid", 32'(tif.count_valid), 1);
    smp(1, 0);
    check("pre_rst_missed", 32'(tif.missed), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(tif.count_valid), 0);
    check("arst_count", 32'(tif.count_out), 0);
    check("arst_ovf", 32'(tif.overflow), 0);
    check("arst_missed", 32'(tif.missed), 0);
    check("arst_busy", 32'(tif.busy), 0);
    tif.enable = 1'b0;
    step();

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
